wme_cmd_sched: RTL

- Command scheduler that sequences the weight_manager exec/inst/data interface.
- Arbitrates between two requesters:
  - host port: register/JTAG side, issues load, readback and clear-all.
  - adaptation port: issues sign-vector increment updates.
- Sits directly in front of weight_manager; sole driver of its data/inst/exec pins.

---
 rtl/wme_sched_pkg.sv | 37 +++
 rtl/wme_rr_arb2.sv | 32 +++
 rtl/wme_cmd_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wme_sched_pkg.sv
// Shared types and wm_inst field layout for the weight_manager command scheduler.
package wme_sched_pkg;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_READ      = 2'd1,
        OP_CLEAR_ALL = 2'd2,
        OP_RSVD      = 2'd3
    } host_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        HOLD     = 3'd2,
        RD_ADDR  = 3'd3,
        RD_CAP   = 3'd4,
        CLR_EXEC = 3'd5,
        CLR_HOLD = 3'd6
    } state_t;

    localparam logic INST_OP_LOAD = 1'b0;
    localparam logic INST_OP_INC  = 1'b1;

    // wm_inst = {op, w_idx, d_idx}
    function automatic int inst_width(input int width, input int depth);
        return 1 + $clog2(width) + $clog2(depth);
    endfunction

    function automatic int inst_w_lsb(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int inst_op_bit(input int width, input int depth);
        return $clog2(width) + $clog2(depth);
    endfunction

endpackage

// File: rtl/wme_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the side not granted last.
module wme_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last; // 1: req[1] was granted most recently

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b0;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/wme_cmd_sched.sv
// Command scheduler in front of weight_manager: arbitrates host and adaptation
// requests and sequences the exec/inst/data pins.
//
// state    | meaning
// IDLE     | ready for a request
// EXEC     | exec pulse for LOAD / increment
// HOLD     | exec low, inst/data still held
// RD_ADDR  | read address presented
// RD_CAP   | read_reg captured at the end of this cycle
// CLR_EXEC | exec pulse for clear entry clr_cnt
// CLR_HOLD | exec low, then next entry or IDLE
module wme_cmd_sched
    import wme_sched_pkg::*;
#(
    parameter int width    = 16,
    parameter int depth    = 8,
    parameter int bitwidth = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 host_valid,
    output logic                                 host_ready,
    input  logic [1:0]                           host_op,
    input  logic [$clog2(width)-1:0]             host_w_idx,
    input  logic [$clog2(depth)-1:0]             host_d_idx,
    input  logic [bitwidth-1:0]                  host_value,
    output logic                                 host_rsp_valid,
    output logic [bitwidth-1:0]                  host_rsp_data,
    input  logic                                 adapt_valid,
    output logic                                 adapt_ready,
    input  logic [$clog2(depth)-1:0]             adapt_d_idx,
    input  logic [2*width-1:0]                   adapt_sign,
    output logic [2*width-1:0]                   wm_data,
    output logic [inst_width(width, depth)-1:0]  wm_inst,
    output logic                                 wm_exec,
    input  logic [bitwidth-1:0]                  wm_read_reg,
    output logic                                 busy
);

    localparam int WW = $clog2(width);
    localparam int CW = $clog2(width) + $clog2(depth);
    localparam int NE = width * depth;

    if (2 * width < bitwidth) begin : g_width_chk
        $error("wme_cmd_sched: 2*width must be >= bitwidth");
    end

    state_t          state;
    host_op_t        op;
    logic [1:0]      grant;
    logic [CW-1:0]   clr_cnt;
    logic [CW-1:0]   clr_nxt;
    logic            clr_last;
    logic [2*width-1:0] load_ext;

    assign op       = host_op_t'(host_op);
    assign clr_nxt  = clr_cnt + CW'(1);
    assign clr_last = (clr_cnt == CW'(NE - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        load_ext = '0;
        load_ext[bitwidth-1:0] = host_value;
    end

    wme_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .req   ({adapt_valid, host_valid}),
        .grant (grant)
    );

    // Ready is the grant itself, so it is only ever offered to a valid requester.
    assign host_ready  = grant[0];
    assign adapt_ready = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wm_inst        <= '0;
            wm_data        <= '0;
            wm_exec        <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rsp_data  <= '0;
            clr_cnt        <= '0;
        end else begin
            host_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        case (op)
                            OP_LOAD: begin
                                wm_inst <= {INST_OP_LOAD, host_w_idx, host_d_idx};
                                wm_data <= load_ext;
                                wm_exec <= 1'b1;
                                state   <= EXEC;
                            end
                            OP_READ: begin
                                wm_inst <= {INST_OP_LOAD, host_w_idx, host_d_idx};
                                state   <= RD_ADDR;
                            end
                            OP_CLEAR_ALL: begin
                                wm_inst <= '0;
                                wm_data <= load_ext;
                                wm_exec <= 1'b1;
                                clr_cnt <= '0;
                                state   <= CLR_EXEC;
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (grant[1]) begin
                        wm_inst <= {INST_OP_INC, {WW{1'b0}}, adapt_d_idx};
                        wm_data <= adapt_sign;
                        wm_exec <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    wm_exec <= 1'b0;
                    state   <= HOLD;
                end
                HOLD:    state <= IDLE;
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    host_rsp_data  <= wm_read_reg;
                    host_rsp_valid <= 1'b1;
                    state          <= IDLE;
                end
                CLR_EXEC: begin
                    wm_exec <= 1'b0;
                    state   <= CLR_HOLD;
                end
                CLR_HOLD: begin
                    if (clr_last) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_nxt;
                        wm_inst <= {INST_OP_LOAD, clr_nxt};
                        wm_exec <= 1'b1;
                        state   <= CLR_EXEC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
